ahb_read_mux_n: RTL and testbench
=================================

Name: ahb_read_mux_n

Overview:
- Parametrised successor to the fixed 3-input, 32-bit read-data mux on the system bus.
- Muxes HRDATA, HREADYOUT and HRESP from NUM_SLAVES slaves back to the master.
- Uses a data-phase select register captured in the address phase, so the response source stays aligned with AHB pipelining.
- Contains a built-in default slave that answers unmapped selects with a two-cycle ERROR response, and a saturating error counter.

Parameters:
- NUM_SLAVES, 3, number of slave response ports (1..2^SEL_WIDTH).
- DATA_WIDTH, 32, read data width in bits.
- SEL_WIDTH, 2, width of the decoder select input.
- CNT_WIDTH, 8, width of the error counter.

Ports:
- CLK  in  1  bus clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- SEL  in  SEL_WIDTH  address-phase slave select from the decoder.
- HTRANS  in  2  address-phase transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HRDATA_BUS  in  NUM_SLAVES*DATA_WIDTH  packed slave read data; slave k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- HREADYOUT_BUS  in  NUM_SLAVES  per-slave HREADYOUT.
- HRESP_BUS  in  NUM_SLAVES  per-slave HRESP (1 = ERROR).
- HRDATA  out  DATA_WIDTH  muxed read data to the master.
- HREADY  out  1  muxed ready; fed back to the master and all slaves.
- HRESP  out  1  muxed response.
- ERR_COUNT  out  CNT_WIDTH  number of default-slave ERROR responses issued; saturates.

Behaviour:
- Data-phase state machine has four states: D_IDLE, D_SLAVE, D_ERR1, D_ERR2.
- Reset (RST=0, asynchronous):
  - state = D_IDLE, sel_q = 0, ERR_COUNT = 0.
  - Outputs therefore HRDATA=0, HREADY=1, HRESP=0.
- Address-phase sampling happens only at a rising edge where HREADY=1:
  - HTRANS[1]=1 and SEL<NUM_SLAVES -> sel_q<=SEL, next state D_SLAVE.
  - HTRANS[1]=1 and SEL>=NUM_SLAVES -> next state D_ERR1.
  - HTRANS[1]=0 (IDLE or BUSY) -> next state D_IDLE (zero-wait OKAY).
- When HREADY=0, state and sel_q hold, except D_ERR1, which always advances to D_ERR2 on the next edge.
- Outputs are combinational from state and sel_q; there is no added latency beyond the AHB address-to-data pipeline:
  - D_IDLE: HRDATA=0, HREADY=1, HRESP=0.
  - D_SLAVE: HRDATA, HREADY and HRESP forward slave sel_q's HRDATA_BUS slice, HREADYOUT_BUS[sel_q] and HRESP_BUS[sel_q].
  - D_ERR1: HRDATA=0, HREADY=0, HRESP=1.
  - D_ERR2: HRDATA=0, HREADY=1, HRESP=1. The next address phase is sampled in this cycle per the rules above.
- Slave wait states: in D_SLAVE with HREADYOUT_BUS[sel_q]=0, the mux holds sel_q for as many cycles as the slave stalls.
- Slave two-cycle ERROR responses are passed through unmodified and do not touch ERR_COUNT.
- ERR_COUNT increments by 1 on each transition into D_ERR1 and saturates at 2^CNT_WIDTH-1; it does not wrap.
- Back-to-back transfers: a new SEL/HTRANS sampled on the final data-phase cycle (HREADY=1) takes effect on the following cycle with no bubble.
- Reset asserted mid-transfer, including D_ERR1/D_ERR2 or a stalled D_SLAVE, returns to reset values immediately; the aborted ERROR is not re-issued.
- Unused sel_q encodings cannot occur in D_SLAVE, because only in-range selects are captured.
- Single-slave configuration (NUM_SLAVES=1) is legal.

Test Plan:
- Reset, then NONSEQ with SEL=0,1,2 in successive cycles; slaves drive 0x12153524 / 0xC0895E81 / 0x8484D609, all HREADYOUT=1 -> HRDATA shows each value one cycle after its address phase; HREADY=1 and HRESP=0 throughout.
- NONSEQ SEL=1, slave 1 holds HREADYOUT=0 for 3 cycles -> HREADY=0 for 3 cycles, then 1 with slave 1 data. A SEL=2 presented during the stall is ignored until the HREADY=1 edge.
- NONSEQ SEL=3 with NUM_SLAVES=3 -> HREADY=0/HRESP=1, then HREADY=1/HRESP=1, HRDATA=0 in both cycles; ERR_COUNT goes 0->1.
- IDLE and BUSY transfers with SEL=3 -> OKAY, zero wait, ERR_COUNT unchanged.
- CNT_WIDTH=2, five unmapped NONSEQ transfers -> ERR_COUNT reads 1,2,3,3,3.
- Assert RST=0 during D_ERR1 -> outputs immediately go to HRDATA=0, HREADY=1, HRESP=0 and ERR_COUNT=0; after release, a NONSEQ SEL=0 completes normally.

Source files
------------

// File: rtl/ahb_read_mux_n.sv
// ahb_read_mux_n: AHB read-response mux for NUM_SLAVES slaves with a data-phase select register,
// a built-in default slave (two-cycle ERROR for unmapped selects) and a saturating error counter.
//   CLK, RST (async, active-low)       clock and reset
//   SEL, HTRANS                        address-phase select and transfer type
//   HRDATA_BUS/HREADYOUT_BUS/HRESP_BUS packed per-slave responses (slave k at slice k)
//   HRDATA/HREADY/HRESP                muxed response to the master
//   ERR_COUNT                          default-slave ERROR responses issued, saturating
module ahb_read_mux_n #(
    parameter int NUM_SLAVES = 3,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [SEL_WIDTH-1:0]             SEL,
    input  logic [1:0]                       HTRANS,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_BUS,
    input  logic [NUM_SLAVES-1:0]            HREADYOUT_BUS,
    input  logic [NUM_SLAVES-1:0]            HRESP_BUS,
    output logic [DATA_WIDTH-1:0]            HRDATA,
    output logic                             HREADY,
    output logic                             HRESP,
    output logic [CNT_WIDTH-1:0]             ERR_COUNT
);
    typedef enum logic [1:0] {D_IDLE, D_SLAVE, D_ERR1, D_ERR2} state_t;
    state_t                state_q, state_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_rdy, s_resp, in_range, unused_htrans;
    assign unused_htrans = HTRANS[0];
    assign in_range = 32'(SEL) < 32'(NUM_SLAVES);
    // Explicit compare loop keeps the select lint-clean for any NUM_SLAVES vs SEL_WIDTH
    always_comb begin
        s_data = '0;
        s_rdy  = 1'b1;
        s_resp = 1'b0;
        for (int k = 0; k < NUM_SLAVES; k++)
            if (sel_q == SEL_WIDTH'(k)) begin
                s_data = HRDATA_BUS[k*DATA_WIDTH +: DATA_WIDTH];
                s_rdy  = HREADYOUT_BUS[k];
                s_resp = HRESP_BUS[k];
            end
    end
    assign HRDATA    = (state_q == D_SLAVE) ? s_data : '0;
    assign HREADY    = (state_q == D_SLAVE) ? s_rdy : (state_q != D_ERR1);
    assign HRESP     = (state_q == D_SLAVE) ? s_resp : (state_q == D_ERR1 || state_q == D_ERR2);
    assign ERR_COUNT = cnt_q;
    // D_ERR1 drives HREADY low itself, so it must advance regardless of HREADY
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        if (state_q == D_ERR1)
            state_d = D_ERR2;
        else if (HREADY) begin
            state_d = !HTRANS[1] ? D_IDLE : (in_range ? D_SLAVE : D_ERR1);
            sel_d   = (HTRANS[1] && in_range) ? SEL : sel_q;
        end
        cnt_d = (state_d == D_ERR1 && cnt_q != '1) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    end
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            state_q <= D_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
endmodule

// File: tb/tb_ahb_read_mux_n.sv
// tb_ahb_read_mux_n: directed self-checking bench for ahb_read_mux_n (default and CNT_WIDTH=2 instances).
module tb_ahb_read_mux_n;
    localparam logic [31:0] S0 = 32'h12153524;
    localparam logic [31:0] S1 = 32'hC0895E81;
    localparam logic [31:0] S2 = 32'h8484D609;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [1:0]  SEL = '0;
    logic [1:0]  HTRANS = 2'b00;
    logic [95:0] HRDATA_BUS;
    logic [2:0]  HREADYOUT_BUS = 3'b111;
    logic [2:0]  HRESP_BUS = 3'b000;
    logic [31:0] hrdata_a, hrdata_b;
    logic        hready_a, hready_b, hresp_a, hresp_b;
    logic [7:0]  cnt_a;
    logic [1:0]  cnt_b;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          exp_sat [5] = '{1, 2, 3, 3, 3};
    assign HRDATA_BUS = {S2, S1, S0};
    always #5 CLK = ~CLK;
    ahb_read_mux_n dut_a (
        .CLK(CLK), .RST(RST), .SEL(SEL), .HTRANS(HTRANS), .HRDATA_BUS(HRDATA_BUS),
        .HREADYOUT_BUS(HREADYOUT_BUS), .HRESP_BUS(HRESP_BUS),
        .HRDATA(hrdata_a), .HREADY(hready_a), .HRESP(hresp_a), .ERR_COUNT(cnt_a)
    );
    ahb_read_mux_n #(.CNT_WIDTH(2)) dut_b (
        .CLK(CLK), .RST(RST), .SEL(SEL), .HTRANS(HTRANS), .HRDATA_BUS(HRDATA_BUS),
        .HREADYOUT_BUS(HREADYOUT_BUS), .HRESP_BUS(HRESP_BUS),
        .HRDATA(hrdata_b), .HREADY(hready_b), .HRESP(hresp_b), .ERR_COUNT(cnt_b)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic chk_rsp(input string tag, input logic [31:0] d, input logic r, input logic e);
        chk({tag, ".hrdata"}, hrdata_a, d);
        chk({tag, ".hready"}, 32'(hready_a), 32'(r));
        chk({tag, ".hresp"}, 32'(hresp_a), 32'(e));
    endtask
    task automatic tick;
        @(posedge CLK);
        #2;
    endtask
    initial begin
        #2;
        chk_rsp("reset", 32'h0, 1'b1, 1'b0);
        chk("reset.cnt_a", 32'(cnt_a), 32'd0);
        chk("reset.cnt_b", 32'(cnt_b), 32'd0);
        #4 RST = 1'b1;
        tick;
        // back-to-back NONSEQ to slaves 0,1,2
        HTRANS = 2'b10; SEL = 2'd0;
        #1 chk_rsp("b2b.idle", 32'h0, 1'b1, 1'b0);
        tick; SEL = 2'd1;
        #1 chk_rsp("b2b.s0", S0, 1'b1, 1'b0);
        tick; SEL = 2'd2;
        #1 chk_rsp("b2b.s1", S1, 1'b1, 1'b0);
        tick; HTRANS = 2'b00;
        #1 chk_rsp("b2b.s2", S2, 1'b1, 1'b0);
        tick;
        #1 chk_rsp("b2b.after", 32'h0, 1'b1, 1'b0);
        // slave 1 stalls three cycles; SEL=2 presented during the stall
        HTRANS = 2'b10; SEL = 2'd1;
        tick; HREADYOUT_BUS = 3'b101; SEL = 2'd2;
        for (int i = 0; i < 3; i++) begin
            #1 chk_rsp($sformatf("stall%0d", i), S1, 1'b0, 1'b0);
            tick;
        end
        HREADYOUT_BUS = 3'b111;
        #1 chk_rsp("stall.done", S1, 1'b1, 1'b0);
        tick; SEL = 2'd3;
        #1 chk_rsp("stall.next_s2", S2, 1'b1, 1'b0);
        // unmapped select -> default slave ERROR
        tick; HTRANS = 2'b00;
        #1 chk_rsp("err1", 32'h0, 1'b0, 1'b1);
        chk("err1.cnt_a", 32'(cnt_a), 32'd1);
        tick;
        #1 chk_rsp("err2", 32'h0, 1'b1, 1'b1);
        chk("err2.cnt_a", 32'(cnt_a), 32'd1);
        tick; HTRANS = 2'b01;
        #1 chk_rsp("idle.sel3", 32'h0, 1'b1, 1'b0);
        tick; HTRANS = 2'b00;
        #1 chk_rsp("busy.sel3", 32'h0, 1'b1, 1'b0);
        chk("busy.cnt_a", 32'(cnt_a), 32'd1);
        // reset pulse, then five unmapped transfers; narrow counter saturates
        RST = 1'b0;
        #1 chk("rst2.cnt_a", 32'(cnt_a), 32'd0);
        RST = 1'b1;
        HTRANS = 2'b10; SEL = 2'd3;
        for (int i = 0; i < 5; i++) begin
            tick;
            #1 chk($sformatf("sat%0d.hready", i), 32'(hready_a), 32'd0);
            chk($sformatf("sat%0d.cnt_b", i), 32'(cnt_b), 32'(exp_sat[i]));
            chk($sformatf("sat%0d.cnt_a", i), 32'(cnt_a), 32'(i + 1));
            tick;
            if (i == 4) HTRANS = 2'b00;
        end
        tick;
        // reset during D_ERR1
        HTRANS = 2'b10; SEL = 2'd3;
        tick; HTRANS = 2'b00;
        #1 chk_rsp("abort.err1", 32'h0, 1'b0, 1'b1);
        RST = 1'b0;
        #1 chk_rsp("abort.rst", 32'h0, 1'b1, 1'b0);
        chk("abort.cnt_a", 32'(cnt_a), 32'd0);
        chk("abort.cnt_b", 32'(cnt_b), 32'd0);
        RST = 1'b1; HTRANS = 2'b10; SEL = 2'd0;
        tick; HTRANS = 2'b00;
        #1 chk_rsp("abort.s0", S0, 1'b1, 1'b0);
        chk("abort.hrdata_b", hrdata_b, S0);
        tick;
        #1 chk_rsp("abort.idle", 32'h0, 1'b1, 1'b0);
        chk("abort.cnt_end", 32'(cnt_a), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
